clk_div_n: RTL
==============

// Module: clk_div_n
// PURPOSE
//  Runtime-programmable integer clock divider; generalises the fixed divide-by-3 block.
//  Generates a divided clock_out plus a one-cycle tick strobe at the end of each period.
//  Divisor is loaded at runtime and applied glitch-free on a period boundary.
//  Feeds slow peripheral timing and strobe generation from the system clock.
// PARAMETERS
//  WIDTH        8   width of the divisor and the phase counter
//  DEFAULT_DIV  3   divisor after reset; must be >=2 and <2**WIDTH
// PORTS
//  clock_in    in   1      system clock; all logic on posedge (negedge only under macro)
//  reset       in   1      synchronous, active-high reset
//  enable      in   1      1 = run divider; 0 = hold idle
//  div_in      in   WIDTH  requested divisor N
//  div_load    in   1      1-cycle strobe: capture div_in as pending divisor
//  clock_out   out  1      divided clock, registered
//  tick        out  1      registered strobe, high during last cycle (phase N-1) of each period
//  div_active  out  WIDTH  divisor currently in effect
//  div_err     out  1      1-cycle pulse: div_load rejected (div_in < 2)
// BEHAVIOUR
//  Reset values: clock_out=0, tick=0, div_err=0, div_active=DEFAULT_DIV; phase idle; no pending divisor.
//  Period: N = div_active cycles, phases 0..N-1; H = ceil(N/2).
//  clock_out=1 in phases 0..H-1, 0 in phases H..N-1. Odd N: high 1 cycle longer than low.
//  First enabled posedge after reset or after enable rises enters phase 0 (clock_out->1).
//  Phase N-1 wraps to phase 0 on the next enabled edge; tick=1 only in phase N-1.
//  enable=0 at an edge: phase goes idle; clock_out=0 and tick=0 from that edge on.
//   On re-enable, a fresh period starts at phase 0; no partial period resumes.
//  div_load with div_in>=2: value goes to a pending register, pend_valid=1. A later load overwrites it.
//   Pending is applied at the edge leaving phase N-1, or at the next edge while idle.
//   div_active updates at that edge; the new period runs at the new N from phase 0.
//   Load in the same cycle as phase N-1: applied at that boundary, no extra period.
//  div_load with div_in<2: no state change, div_err=1 for exactly the next cycle.
//  Current period always finishes at the old N; no runt or stretched pulse beyond the new N.
//  Reset mid-period: all outputs return to reset values at that edge; pending is discarded.
//  Counter compares are WIDTH bits, unsigned. Max N = 2**WIDTH-1.
// CONFIGURATION
//  CLK_DIV_ODD_DUTY50_EN defined:
//   Odd N gives exact 50% duty. Posedge term is high in phases 0..(N-1)/2-1.
//   A negedge flop samples that term; clock_out = pos_term | neg_term, so high N/2 cycles.
//   Even N: negedge term forced 0, same as without the macro.
//   In this mode clock_out is an OR of two flops.
//  CLK_DIV_ODD_DUTY50_EN undefined: posedge logic only; odd duty = ceil(N/2):floor(N/2).
// STRUCTURE
//  Package clk_div_pkg: div_t (logic [WIDTH-1:0]), DIV_MIN=2, phase-state enum {IDLE, RUN}.
//  One sub-module, clk_div_phase_ctr: phase counter with wrap, idle handling and pending-load apply.
//  Top level holds the duty/tick decode, error pulse and optional negedge path.
// TESTING
//  1 Reset 2 cyc, enable=1, DEFAULT_DIV=3, run 20 cyc -> clock_out 1,1,0 repeating; tick every 3rd cyc.
//  2 N=3 running; load 4 in phase 0 -> finish 1,1,0; then 1,1,0,0; div_active=4 at boundary.
//  3 div_load with div_in=1, then div_in=0 -> div_err pulses 1 cyc each; div_active stays 3.
//  4 Drop enable in phase 1 for 3 cyc, re-enable -> clock_out=0 while idle; restart at phase 0.
//  5 Reset asserted mid-period with pending=6 -> outputs at reset values; div_active=3; pending lost.
//  6 Macro defined, N=5 -> clock_out high exactly 2.5 cyc, low 2.5 cyc; N=4 -> 2/2.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_WIDTH = 8;
  localparam int unsigned DIV_MIN       = 2;

  typedef logic [CLK_DIV_WIDTH-1:0] div_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } phase_state_e;

endpackage

// File: rtl/clk_div_phase_ctr.sv
// Phase counter: wraps at div-1, idles on !enable, and swaps in a pending divisor
// only on a period boundary or while idle so no period is ever cut or stretched.
module clk_div_phase_ctr
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = CLK_DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_div_i,
  output phase_state_e     state_d_o,
  output logic [WIDTH-1:0] phase_d_o,
  output logic [WIDTH-1:0] div_d_o,
  output logic [WIDTH-1:0] div_q_o
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  phase_state_e     state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;

  logic             boundary;
  logic             eff_valid;
  logic [WIDTH-1:0] eff_div;
  logic             apply;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      div_q        <= DEF_DIV;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    boundary  = (phase_q == (div_q - ONE));
    // A load arriving in the boundary cycle itself takes effect at that boundary.
    eff_valid = load_i | pend_valid_q;
    eff_div   = load_i ? load_div_i : pend_q;
    apply     = eff_valid && ((state_q == IDLE) || (enable_i && boundary));

    if (load_i) begin
      pend_d       = load_div_i;
      pend_valid_d = 1'b1;
    end
    if (apply) begin
      div_d        = eff_div;
      pend_valid_d = 1'b0;
    end

    if (!enable_i) begin
      state_d = IDLE;
      phase_d = '0;
    end else if ((state_q == IDLE) || boundary) begin
      state_d = RUN;
      phase_d = '0;
    end else begin
      phase_d = phase_q + ONE;
    end
  end

  assign state_d_o = state_d;
  assign phase_d_o = phase_d;
  assign div_d_o   = div_d;
  assign div_q_o   = div_q;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with end-of-period tick strobe.
// Define CLK_DIV_ODD_DUTY50_EN for exact 50% duty on odd divisors (adds a negedge flop).
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = CLK_DIV_WIDTH,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clock_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_MIN_W = WIDTH'(DIV_MIN);

  logic load_bad;
  logic load_ok;

  assign load_bad = div_load && (div_in < DIV_MIN_W);
  assign load_ok  = div_load && !load_bad;

  phase_state_e     state_d;
  logic [WIDTH-1:0] phase_d;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] div_q;

  clk_div_phase_ctr #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_phase_ctr (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable_i   (enable),
    .load_i     (load_ok),
    .load_div_i (div_in),
    .state_d_o  (state_d),
    .phase_d_o  (phase_d),
    .div_d_o    (div_d),
    .div_q_o    (div_q)
  );

  // Outputs decode the next phase so they are registered alongside it.
  logic [WIDTH-1:0] high_thr;
`ifdef CLK_DIV_ODD_DUTY50_EN
  assign high_thr = div_d >> 1;
`else
  assign high_thr = (div_d >> 1) + {{(WIDTH-1){1'b0}}, div_d[0]};
`endif

  logic pos_d, pos_q;
  logic tick_d, tick_q;
  logic err_q;
  logic run_d, run_q;

  assign run_d  = (state_d == RUN);
  assign pos_d  = run_d && (phase_d < high_thr);
  assign tick_d = run_d && (phase_d == (div_d - ONE));

  always_ff @(posedge clock_in) begin
    if (reset) begin
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      tick_q <= tick_d;
      err_q  <= load_bad;
      run_q  <= run_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle extension of the high phase; only meaningful for odd divisors.
  always_ff @(negedge clock_in) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & div_q[0];
    end
  end

  assign clock_out = pos_q | (neg_q & run_q);
`else
  logic unused_run;
  assign unused_run = run_q;
  assign clock_out  = pos_q;
`endif

  assign tick       = tick_q;
  assign div_active = div_q;
  assign div_err    = err_q;

endmodule
